// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
   localparam int XLEN = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [1:0]      size;
      logic            is_unsigned;
      logic [XLEN-1:0] wdata;
   } dmem_req_t;
endpackage

// File: rtl/dmem_if.sv
// Request/response handshake bundle between the memory stage and the responder.
interface dmem_if;
   import dmem_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic            req_we;
   logic [XLEN-1:0] req_addr;
   logic [1:0]      req_size;
   logic            req_unsigned;
   logic [XLEN-1:0] req_wdata;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_rdata;
   logic            rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// DMEM_MISALIGN_TRAP_EN: misaligned accesses write no lanes and read back 0.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]      addr_lo,
   input  logic [1:0]      size,
   input  logic            is_unsigned,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wword,
   output logic [XLEN-1:0] rext,
   output logic            misalign
);
   logic [1:0]  ea;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   always_comb begin
      misalign = ((size == SZ_HALF) && addr_lo[0]) ||
                 ((size == SZ_WORD) && (addr_lo != 2'b00)) ||
                 (size == SZ_RSVD);
      ea    = 2'b00;
      be    = 4'b1111;
      wword = wdata;
      // half/word force low address bits to zero so they stay aligned
      case (size)
         SZ_BYTE: begin
            ea    = addr_lo;
            be    = 4'b0001 << addr_lo;
            wword = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            ea    = {addr_lo[1], 1'b0};
            be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata[15:0]}};
         end
         default: ;
      endcase

      rbyte = rdata[{ea, 3'b000} +: 8];
      rhalf = ea[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: rext = {{24{~is_unsigned & rbyte[7]}}, rbyte};
         SZ_HALF: rext = {{16{~is_unsigned & rhalf[15]}}, rhalf};
         default: rext = rdata;
      endcase
`ifdef DMEM_MISALIGN_TRAP_EN
      if (misalign) begin
         be   = 4'b0000;
         rext = '0;
      end
`endif
   end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, WAIT_CYCLES wait states, byte lanes.
// DMEM_MISALIGN_TRAP_EN: flag misaligned/reserved accesses on rsp_err instead of aligning.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int    DEPTH_WORDS = 1024,
   parameter int    WAIT_CYCLES = 1,
   parameter string INIT_FILE   = ""
) (
   input logic   clk,
   input logic   rst_n,
   dmem_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_LD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   dmem_state_t     state, nxt;
   logic [3:0]      cnt;
   dmem_req_t       bus_req, req_q, cur;
   logic            access;
   logic [AW-1:0]   idx;
   logic [XLEN-1:0] rd_word, wword, rext, rdata_q;
   logic [3:0]      be;
   logic            misalign;
   logic            unused_hi;

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   assign bus_req = '{we: bus.req_we, addr: bus.req_addr, size: bus.req_size,
                      is_unsigned: bus.req_unsigned, wdata: bus.req_wdata};

   // with zero wait states the access happens on the accept edge, straight off the bus
   assign cur       = (state == IDLE) ? bus_req : req_q;
   assign idx       = cur.addr[AW+1:2];
   assign rd_word   = mem[idx];
   assign unused_hi = ^cur.addr[XLEN-1:AW+2];

   dmem_lane_align u_align (
      .addr_lo     (cur.addr[1:0]),
      .size        (cur.size),
      .is_unsigned (cur.is_unsigned),
      .wdata       (cur.wdata),
      .rdata       (rd_word),
      .be          (be),
      .wword       (wword),
      .rext        (rext),
      .misalign    (misalign)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt           = state;
      access        = 1'b0;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  access = 1'b1;
                  nxt    = RESP;
               end else begin
                  nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               access = 1'b1;
               nxt    = RESP;
            end
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= 4'd0;
         req_q   <= '0;
         rdata_q <= '0;
      end else begin
         if (state == IDLE && bus.req_valid) begin
            req_q <= bus_req;
            cnt   <= WAIT_LD;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (access) rdata_q <= cur.we ? '0 : rext;
      end
   end

   // array is deliberately not reset; only the access edge writes it
   always_ff @(posedge clk) begin
      if (access && cur.we) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
   end

   assign bus.rsp_rdata = rdata_q;

`ifdef DMEM_MISALIGN_TRAP_EN
   logic err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      err_q <= 1'b0;
      else if (access) err_q <= misalign;
   end
   assign bus.rsp_err = err_q;
`else
   logic unused_misalign;
   assign unused_misalign = misalign;
   assign bus.rsp_err     = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector tables plus reset/backpressure sequences.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int W = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_if bus();

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(W), .INIT_FILE("")) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   int   n_chk = 0;
   int   n_pass = 0;
   vec_t tab_a[$];
   vec_t tab_b[$];

   function automatic vec_t mk(string name, logic we, logic [31:0] addr, logic [1:0] size,
                               logic uns, logic [31:0] wdata, logic [31:0] er, logic ee);
      vec_t v;
      v.name = name; v.we = we; v.addr = addr; v.size = size; v.uns = uns;
      v.wdata = wdata; v.exp_rdata = er; v.exp_err = ee;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      n_chk++;
      $display("FAIL %s: timed out waiting on handshake", name);
   endtask

   task automatic drive(input vec_t v);
      bus.req_we       = v.we;
      bus.req_addr     = v.addr;
      bus.req_size     = v.size;
      bus.req_unsigned = v.uns;
      bus.req_wdata    = v.wdata;
   endtask

   // count edges from the accept edge until rsp_valid is seen at a negedge
   task automatic wait_rsp(input string name, output int lat, output bit ok);
      ok  = 1'b0;
      lat = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin ok = 1'b1; break; end
         lat++;
      end
      if (!ok) timeout(name);
   endtask

   task automatic issue(input vec_t v, output int lat, output bit ok);
      @(negedge clk);
      drive(v);
      bus.req_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.req_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      lat = 0;
      if (!ok) begin
         bus.req_valid = 1'b0;
         timeout({v.name, " accept"});
      end else begin
         @(posedge clk);
         #1 bus.req_valid = 1'b0;
         wait_rsp(v.name, lat, ok);
      end
   endtask

   task automatic release_rsp();
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
   endtask

   task automatic run(input vec_t v);
      int lat;
      bit ok;
      issue(v, lat, ok);
      if (ok) begin
         chk({v.name, " rdata"}, bus.rsp_rdata, v.exp_rdata);
         chk({v.name, " err"}, {31'b0, bus.rsp_err}, {31'b0, v.exp_err});
         chk({v.name, " latency"}, 32'(lat), 32'(W + 1));
         release_rsp();
         @(negedge clk);
         chk({v.name, " idle"}, {30'b0, bus.req_ready, bus.rsp_valid}, 32'h2);
      end
   endtask

   initial begin
      int lat;
      bit ok;
      vec_t v;

      bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
      bus.req_we = 1'b0; bus.req_addr = '0; bus.req_size = SZ_WORD;
      bus.req_unsigned = 1'b0; bus.req_wdata = '0;

      tab_a.push_back(mk("sw_10",   1, 32'h10,  SZ_WORD, 0, 32'hDEADBEEF, 32'h0,        0));
      tab_a.push_back(mk("lw_10",   0, 32'h10,  SZ_WORD, 0, 32'h0,        32'hDEADBEEF, 0));
      tab_a.push_back(mk("lb_13",   0, 32'h13,  SZ_BYTE, 0, 32'h0,        32'hFFFFFFDE, 0));
      tab_a.push_back(mk("lbu_13",  0, 32'h13,  SZ_BYTE, 1, 32'h0,        32'h000000DE, 0));
      tab_a.push_back(mk("lh_10",   0, 32'h10,  SZ_HALF, 0, 32'h0,        32'hFFFFBEEF, 0));
      tab_a.push_back(mk("lhu_12",  0, 32'h12,  SZ_HALF, 1, 32'h0,        32'h0000DEAD, 0));
      tab_a.push_back(mk("sb_11",   1, 32'h11,  SZ_BYTE, 0, 32'h000000AA, 32'h0,        0));
      tab_a.push_back(mk("lw_10b",  0, 32'h10,  SZ_WORD, 0, 32'h0,        32'hDEADAAEF, 0));
      tab_a.push_back(mk("lb_11",   0, 32'h11,  SZ_BYTE, 0, 32'h0,        32'hFFFFFFAA, 0));
      tab_a.push_back(mk("lbu_12",  0, 32'h12,  SZ_BYTE, 1, 32'h0,        32'h000000AD, 0));
      tab_a.push_back(mk("lw_alias",0, 32'h110, SZ_WORD, 0, 32'h0,        32'hDEADAAEF, 0));
      tab_a.push_back(mk("sw_14",   1, 32'h14,  SZ_WORD, 0, 32'h11223344, 32'h0,        0));
      tab_a.push_back(mk("sh_16",   1, 32'h16,  SZ_HALF, 0, 32'h12348001, 32'h0,        0));
      tab_a.push_back(mk("lw_14",   0, 32'h14,  SZ_WORD, 0, 32'h0,        32'h80013344, 0));
      tab_a.push_back(mk("lh_16",   0, 32'h16,  SZ_HALF, 0, 32'h0,        32'hFFFF8001, 0));
      tab_a.push_back(mk("lhu_14",  0, 32'h14,  SZ_HALF, 1, 32'h0,        32'h00003344, 0));
      tab_a.push_back(mk("sw_18",   1, 32'h18,  SZ_WORD, 0, 32'h00000000, 32'h0,        0));
      tab_a.push_back(mk("sb_1b",   1, 32'h1B,  SZ_BYTE, 0, 32'hFFFFFF7F, 32'h0,        0));
      tab_a.push_back(mk("lw_18",   0, 32'h18,  SZ_WORD, 1, 32'h0,        32'h7F000000, 0));
      tab_a.push_back(mk("lb_1b",   0, 32'h1B,  SZ_BYTE, 0, 32'h0,        32'h0000007F, 0));
      tab_a.push_back(mk("sw_20",   1, 32'h20,  SZ_WORD, 0, 32'hCAFEF00D, 32'h0,        0));
      tab_a.push_back(mk("sw_24",   1, 32'h24,  SZ_WORD, 0, 32'h00000000, 32'h0,        0));

`ifdef DMEM_MISALIGN_TRAP_EN
      tab_b.push_back(mk("lw_22_mis",  0, 32'h22, SZ_WORD, 0, 32'h0,        32'h0,        1));
      tab_b.push_back(mk("lh_21_mis",  0, 32'h21, SZ_HALF, 0, 32'h0,        32'h0,        1));
      tab_b.push_back(mk("rsvd_20",    0, 32'h20, SZ_RSVD, 0, 32'h0,        32'h0,        1));
      tab_b.push_back(mk("sw_26_mis",  1, 32'h26, SZ_WORD, 0, 32'hFFFFFFFF, 32'h0,        1));
      tab_b.push_back(mk("lw_24",      0, 32'h24, SZ_WORD, 0, 32'h0,        32'h00000000, 0));
`else
      tab_b.push_back(mk("lw_22_mis",  0, 32'h22, SZ_WORD, 0, 32'h0,        32'hCAFEF00D, 0));
      tab_b.push_back(mk("lh_21_mis",  0, 32'h21, SZ_HALF, 0, 32'h0,        32'hFFFFF00D, 0));
      tab_b.push_back(mk("rsvd_20",    0, 32'h20, SZ_RSVD, 0, 32'h0,        32'hCAFEF00D, 0));
      tab_b.push_back(mk("sw_26_mis",  1, 32'h26, SZ_WORD, 0, 32'hFFFFFFFF, 32'h0,        0));
      tab_b.push_back(mk("lw_24",      0, 32'h24, SZ_WORD, 0, 32'h0,        32'hFFFFFFFF, 0));
`endif
      tab_b.push_back(mk("lh_22",      0, 32'h22, SZ_HALF, 0, 32'h0,        32'hFFFFCAFE, 0));

      // reset state
      #12;
      chk("rst req_ready", {31'b0, bus.req_ready}, 32'h1);
      chk("rst rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
      chk("rst rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst rsp_err",   {31'b0, bus.rsp_err}, 32'h0);
      @(negedge clk) rst_n = 1'b1;

      foreach (tab_a[i]) run(tab_a[i]);

      // backpressure, with a new request waiting that must not ride the response edge
      issue(mk("bp_lw_10", 0, 32'h10, SZ_WORD, 0, 32'h0, 32'h0, 0), lat, ok);
      if (ok) begin
         drive(mk("bp_lw_14", 0, 32'h14, SZ_WORD, 0, 32'h0, 32'h0, 0));
         bus.req_valid = 1'b1;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp rsp_valid", {31'b0, bus.rsp_valid}, 32'h1);
            chk("bp rsp_rdata", bus.rsp_rdata, 32'hDEADAAEF);
            chk("bp req_ready", {31'b0, bus.req_ready}, 32'h0);
         end
         release_rsp();
         @(negedge clk);
         chk("bp after release", {30'b0, bus.req_ready, bus.rsp_valid}, 32'h2);
         @(posedge clk);
         #1 bus.req_valid = 1'b0;
         wait_rsp("bp_lw_14", lat, ok);
         if (ok) begin
            chk("bp_lw_14 rdata", bus.rsp_rdata, 32'h80013344);
            chk("bp_lw_14 latency", 32'(lat), 32'(W + 1));
            release_rsp();
         end
      end

      // reset while a store sits in WAIT: store is dropped
      @(negedge clk);
      drive(mk("sw_20_drop", 1, 32'h20, SZ_WORD, 0, 32'h12345678, 32'h0, 0));
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      chk("wait req_ready", {31'b0, bus.req_ready}, 32'h0);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("midrst rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
      chk("midrst req_ready", {31'b0, bus.req_ready}, 32'h1);
      chk("midrst rsp_rdata", bus.rsp_rdata, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      run(mk("lw_20_kept", 0, 32'h20, SZ_WORD, 0, 32'h0, 32'hCAFEF00D, 0));

      // reset while in RESP: the store already happened
      issue(mk("sw_28", 1, 32'h28, SZ_WORD, 0, 32'hA5A5A5A5, 32'h0, 0), lat, ok);
      rst_n = 1'b0;
      #1 chk("resp_rst rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      run(mk("lw_28", 0, 32'h28, SZ_WORD, 0, 32'h0, 32'hA5A5A5A5, 0));

      foreach (tab_b[i]) run(tab_b[i]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
